// File: rtl/rr_arb8.sv
// rr_arb8: 8-source round-robin arbiter with a registered one-hot grant,
// a registered source index for the mux8to1 and an optional hold timeout.
//
// Parameters:
//   TIMEOUT  max cycles a grant may be held (2..65535); used only when the
//            optional timeout is compiled in
//   PARK     sel_o value driven from reset until the first grant
//
// Ports:
//   clock_i    in   1  sole clock, rising edge
//   reset_i    in   1  synchronous, active-high reset
//   req_i      in   8  request lines, bit n = source n
//   done_i     in   1  grantee finished; sampled only while valid_o=1
//   gnt_o      out  8  registered one-hot grant, zero when idle
//   sel_o      out  3  registered index of the granted source
//   valid_o    out  1  registered, high while a grant is held
//   timeout_o  out  1  registered one-cycle pulse on a forced release
//
// Optional feature: define RR_ARB8_TIMEOUT_EN to compile in the hold
// counter. Without it timeout_o is tied low and grants never expire.

module rr_arb8 #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [2:0]  PARK    = 3'd0
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic [2:0] sel_o,
  output logic       valid_o,
  output logic       timeout_o
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  logic       found;
  logic [2:0] pick;
  logic       release_n;

`ifdef RR_ARB8_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
`endif

  // First requester at or above ptr, wrapping 7 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req_i[ptr_q + 3'(i)]) begin
        found = 1'b1;
        pick  = ptr_q + 3'(i);
      end
    end
  end

  // done and a request drop in the same cycle fold into one release.
  assign release_n = done_i || !req_i[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
`ifdef RR_ARB8_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        gnt_d   = 8'h00;
        valid_d = 1'b0;
        if (found) begin
          state_d = S_GRANT;
          gnt_d   = 8'h01 << pick;
          sel_d   = pick;
          valid_d = 1'b1;
`ifdef RR_ARB8_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      S_GRANT: begin
        if (release_n) begin
          state_d = S_IDLE;
          ptr_d   = sel_q + 3'd1;
          gnt_d   = 8'h00;
          valid_d = 1'b0;
`ifdef RR_ARB8_TIMEOUT_EN
        end else if (cnt_q >= LIMIT) begin
          // Forced release; a normal release above wins on the same cycle.
          state_d = S_IDLE;
          ptr_d   = sel_q + 3'd1;
          gnt_d   = 8'h00;
          valid_d = 1'b0;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      gnt_q   <= 8'h00;
      sel_q   <= PARK;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

`ifdef RR_ARB8_TIMEOUT_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= 16'd0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_o   = gnt_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed scoreboard bench for rr_arb8 (PARK=3, TIMEOUT=4).
// Expected outputs are queued when a step is driven and checked after the edge.

module tb_rr_arb8;

  logic       clock_i;
  logic       reset_i;
  logic [7:0] req_i;
  logic       done_i;
  logic [7:0] gnt_o;
  logic [2:0] sel_o;
  logic       valid_o;
  logic       timeout_o;

  int tests;
  int fails;

  typedef struct {
    logic       v;
    logic [7:0] g;
    logic [2:0] s;
    logic       t;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_arb8 #(
    .TIMEOUT(4),
    .PARK(3'd3)
  ) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .req_i    (req_i),
    .done_i   (done_i),
    .gnt_o    (gnt_o),
    .sel_o    (sel_o),
    .valid_o  (valid_o),
    .timeout_o(timeout_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic step(input logic [7:0] r, input logic d,
                      input logic rst, input logic ev,
                      input logic [2:0] es, input logic et,
                      input string tag);
    exp_t e;
    exp_t x;
    req_i   = r;
    done_i  = d;
    reset_i = rst;
    e.v   = ev;
    e.g   = ev ? (8'h01 << es) : 8'h00;
    e.s   = es;
    e.t   = et;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock_i);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty got 0 entries required 1", tag);
    end else begin
      x = sb.pop_front();
      tests++;
      assert (valid_o === x.v) else begin
        fails++;
        $error("FAIL %s valid_o got %0b required %0b", x.tag, valid_o, x.v);
      end
      tests++;
      assert (gnt_o === x.g) else begin
        fails++;
        $error("FAIL %s gnt_o got %02h required %02h", x.tag, gnt_o, x.g);
      end
      tests++;
      assert (sel_o === x.s) else begin
        fails++;
        $error("FAIL %s sel_o got %0d required %0d", x.tag, sel_o, x.s);
      end
      tests++;
      assert (timeout_o === x.t) else begin
        fails++;
        $error("FAIL %s timeout_o got %0b required %0b", x.tag, timeout_o, x.t);
      end
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_i = 1'b1;
    req_i   = 8'h00;
    done_i  = 1'b0;

    // Reset and parked idle
    step(8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, "reset");
    step(8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, "reset2");
    for (int i = 0; i < 10; i++)
      step(8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, "park_idle");

    // 0x24 from ptr 0: source 2, idle, then source 5
    step(8'h24, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, "g2");
    step(8'h24, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, "g2_hold");
    step(8'h24, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, "g2_done");
    step(8'h24, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, "g5");
    // Other request bits do not disturb the grant
    step(8'h2F, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, "g5_other");
    // Grantee drops its request -> release, ptr=6
    step(8'h0F, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, "g5_drop");

    // Wrap: ptr=6 with 0x41 -> 6 then 0
    step(8'h41, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, "wrap_g6");
    step(8'h41, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, "wrap_rel6");
    step(8'h41, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "wrap_g0");
    // done and drop together: one release only
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "both_rel");
    step(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "both_idle");
    // done ignored in idle
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "done_idle");

    // Reset with a request present, then full rotation with 0xFF
    step(8'hFF, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, "rst_req");
    step(8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "rot_g0");
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF, 1'b1, 1'b0, 1'b0, 3'(k - 1), 1'b0, "rot_rel");
      step(8'hFF, 1'b0, 1'b0, 1'b1, 3'(k), 1'b0, "rot_grant");
    end

    // Reset during a grant of source 5
    step(8'h20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "pre5_rel");
    step(8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, "pre5_g5");
    step(8'h20, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, "rst_in_grant");
    step(8'h21, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "post_rst_g0");
    step(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "post_rst_rel");

    // Timeout behaviour, req=0x03, done=0
    step(8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, "to_reset");
    step(8'h03, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "to_g0");
    for (int i = 0; i < 3; i++)
      step(8'h03, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "to_hold0");
`ifdef RR_ARB8_TIMEOUT_EN
    step(8'h03, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, "to_pulse");
    step(8'h03, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, "to_g1");
    for (int i = 0; i < 3; i++)
      step(8'h03, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, "to_hold1");
    // Normal release on the limit cycle wins; no pulse
    step(8'h03, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, "to_done_wins");
    step(8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, "to_after");
`else
    for (int i = 0; i < 8; i++)
      step(8'h03, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "no_to_hold");
`endif

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain got %0d entries required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of cycles one grant may be held (range 2..65535).
REQ-002 Parameter PARK, default 0, is the sel_o value driven after reset until the first grant.
REQ-003 clock_i  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 req_i  in  8  request lines; bit n = source n wants the shared datapath.
REQ-006 done_i  in  1  current grantee finished; sampled only while valid_o=1.
REQ-007 gnt_o  out  8  registered one-hot grant; all zero when no grant.
REQ-008 sel_o  out  3  registered index of the granted source; drives the mux8to1 sel_i directly.
REQ-009 valid_o  out  1  registered; high while a grant is held.
REQ-010 timeout_o  out  1  registered one-cycle pulse on a forced release.

Function
REQ-011 The block SHALL implement two states, IDLE and GRANT, plus a 3-bit priority pointer ptr.
REQ-012 In IDLE with req_i != 0, the block SHALL select the first set bit of req_i at or above ptr, searching upward and wrapping 7 -> 0, then enter GRANT.
REQ-013 Grant latency SHALL be exactly one cycle: gnt_o, sel_o and valid_o update on the edge that samples the request.
REQ-014 In IDLE with req_i == 0, the block SHALL stay in IDLE, with gnt_o=0, valid_o=0 and sel_o holding its last value.
REQ-015 In GRANT, gnt_o and sel_o SHALL remain constant regardless of changes on other req_i bits.
REQ-016 In GRANT, the grant SHALL be released if done_i=1 or if the grantee's req_i bit is 0.
REQ-017 On release, the block SHALL set ptr to (granted index + 1) mod 8, clear gnt_o and valid_o, keep sel_o, and return to IDLE.
REQ-018 Every release SHALL be followed by exactly one idle cycle (valid_o=0) before the next grant; grants are never back-to-back.
REQ-019 When done_i and a grantee req drop occur in the same cycle, the block SHALL perform a single release.
REQ-020 done_i SHALL be ignored in IDLE.
REQ-021 gnt_o SHALL equal (1 << sel_o) whenever valid_o=1, and 0 otherwise.

Reset
REQ-022 When reset_i=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, gnt_o=0, valid_o=0, timeout_o=0, sel_o=PARK and clear the hold counter, overriding any in-progress grant.
REQ-023 A request present on the first edge after reset deasserts SHALL be arbitrated normally from ptr=0.

Configuration
REQ-024 Macro RR_ARB8_TIMEOUT_EN SHALL compile in a hold counter that clears on entry to GRANT and increments each GRANT cycle.
REQ-025 With RR_ARB8_TIMEOUT_EN defined, a grant still held after TIMEOUT cycles with valid_o=1 SHALL be released as in REQ-017, with timeout_o=1 for that one cycle.
REQ-026 With RR_ARB8_TIMEOUT_EN defined, a normal release occurring on the same cycle as the limit SHALL take priority, and timeout_o SHALL stay 0.
REQ-027 Without RR_ARB8_TIMEOUT_EN, no counter SHALL exist, timeout_o SHALL be tied to 0, and grants SHALL be held indefinitely.

Verification
REQ-028 After reset with PARK=3 and req_i=0x00 held for 10 cycles, the bench SHALL check valid_o=0, gnt_o=0x00, sel_o=3 and timeout_o=0 throughout.
REQ-029 From ptr=0, req_i=0x24 SHALL give gnt_o=0x04, sel_o=2 one cycle later; after done_i pulses, one idle cycle SHALL follow, then gnt_o=0x20, sel_o=5.
REQ-030 With req_i=0xFF constant and done_i pulsed on every grant, sel_o SHALL sequence 0,1,...,7,0 with valid_o alternating 1 then 0.
REQ-031 Wrap case: with ptr=6 (after granting source 5) and req_i=0x41, the block SHALL grant source 6 first, then source 0.
REQ-032 With RR_ARB8_TIMEOUT_EN and TIMEOUT=4, req_i=0x03 and done_i=0, the block SHALL grant source 0 for 4 cycles, pulse timeout_o once, idle one cycle, then grant source 1 (gnt_o=0x02); without the macro, source 0 SHALL hold indefinitely.
REQ-033 Asserting reset_i during a grant of source 5 SHALL clear gnt_o and valid_o and set sel_o=PARK on that edge, and the next grant SHALL start the search from source 0.
